// File: rtl/inst_encoder_pkg.sv
// Shared RV32I instruction constants. The immediate decoder uses the same values,
// so the encoder and decoder cannot drift apart.
package inst_encoder_pkg;

  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic in_range(input logic [31:0] value, input int lo, input int hi);
    return (int'(value) >= lo) && (int'(value) <= hi);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush. The head word is presented combinationally on dout.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs opcode, register/funct fields and a signed immediate into an RV32I word.
// Unrepresentable immediates or unknown opcodes are replaced by NOP and flagged.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [31:0] enc_word;
  logic        enc_err;
  logic [32:0] head;
  logic        full;
  logic        empty;
  logic        accept;

  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR: begin
        enc_err  = !in_range(imm, -2048, 2047);
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OP_S: begin
        enc_err  = !in_range(imm, -2048, 2047);
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      OP_B: begin
        enc_err  = !in_range(imm, -4096, 4094) || imm[0];
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      OP_LUI, OP_AUIPC: begin
        enc_err  = (imm[11:0] != 12'h0);
        enc_word = {imm[31:12], rd, opcode};
      end
      OP_JAL: begin
        enc_err  = !in_range(imm, -1048576, 1048574) || imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      OP_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = NOP_WORD;
  end

  // in_ready deliberately ignores out_ready: a full FIFO blocks even if it pops this cycle.
  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign out_inst  = empty ? 32'h0 : head[31:0];
  assign out_err   = !empty && head[32];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (accept),
    .pop   (out_valid && out_ready),
    .din   ({enc_err, enc_word}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      if (acc_cnt != '1)            acc_cnt <= acc_cnt + CNT_W'(1);
      if (enc_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against a queue-based reference model with an
// independent immediate decoder for round-trip checking.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [6:0]       opcode, funct7;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [31:0]      imm, out_inst;
  logic [CNT_W-1:0] acc_cnt, err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] imm;
    logic [6:0]  op;
  } ent_t;

  ent_t q[$];
  int   m_acc, m_err;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .acc_cnt(acc_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: fields placed with shifts/masks from the RV32I layouts.
  function automatic ent_t model_enc(input logic [6:0] op, input logic [31:0] r_d,
                                     input logic [31:0] r_1, input logic [31:0] r_2,
                                     input logic [31:0] f3, input logic [31:0] f7,
                                     input logic [31:0] u);
    ent_t e;
    int   s = int'(u);
    e.op = op; e.imm = u; e.err = 1'b0; e.inst = 32'h0;
    if (op == OP_I || op == OP_LOAD || op == OP_JALR) begin
      e.err  = (s < -2048) || (s > 2047);
      e.inst = ((u & 32'hfff) << 20) | (r_1 << 15) | (f3 << 12) | (r_d << 7) | 32'(op);
    end else if (op == OP_S) begin
      e.err  = (s < -2048) || (s > 2047);
      e.inst = (((u >> 5) & 32'h7f) << 25) | (r_2 << 20) | (r_1 << 15) | (f3 << 12)
             | ((u & 32'h1f) << 7) | 32'(op);
    end else if (op == OP_B) begin
      e.err  = (s < -4096) || (s > 4094) || (u % 2 == 1);
      e.inst = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (r_2 << 20)
             | (r_1 << 15) | (f3 << 12) | (((u >> 1) & 32'hf) << 8)
             | (((u >> 11) & 1) << 7) | 32'(op);
    end else if (op == OP_LUI || op == OP_AUIPC) begin
      e.err  = (u % 4096) != 0;
      e.inst = (u & 32'hffff_f000) | (r_d << 7) | 32'(op);
    end else if (op == OP_JAL) begin
      e.err  = (s < -1048576) || (s > 1048574) || (u % 2 == 1);
      e.inst = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21)
             | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | (r_d << 7) | 32'(op);
    end else if (op == OP_R) begin
      e.inst = (f7 << 25) | (r_2 << 20) | (r_1 << 15) | (f3 << 12) | (r_d << 7) | 32'(op);
    end else begin
      e.err = 1'b1;
    end
    if (e.err) e.inst = 32'h0000_0013;
    return e;
  endfunction

  // Independent immediate decoder, as the pipeline would apply it.
  function automatic logic [31:0] dec_imm(input logic [31:0] w);
    int sw = int'(w);
    case (w[6:0])
      OP_I, OP_LOAD, OP_JALR: return 32'(sw >>> 20);
      OP_S:   return 32'((sw >>> 25) * 32 + int'(w[11:7]));
      OP_B:   return 32'((sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                         + int'(w[11:8]) * 2);
      OP_LUI, OP_AUIPC: return w & 32'hffff_f000;
      OP_JAL: return 32'((sw >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                         + int'(w[30:21]) * 2);
      default: return 32'h0;
    endcase
  endfunction

  task automatic cycle();
    logic acc, pop;
    ent_t e;
    @(negedge clk);
    if (!rst) begin
      check("out_valid", out_valid, q.size() > 0);
      check("out_inst", out_inst, q.size() > 0 ? q[0].inst : 32'h0);
      check("out_err", out_err, q.size() > 0 ? q[0].err : 1'b0);
      check("in_ready", in_ready, (q.size() < DEPTH) && !flush);
      check("acc_cnt", acc_cnt, m_acc);
      check("err_cnt", err_cnt, m_err);
      if (q.size() > 0 && !q[0].err && q[0].op != OP_R)
        check("roundtrip", dec_imm(out_inst), q[0].imm);
    end
    acc = !rst && in_valid && (q.size() < DEPTH) && !flush;
    pop = !rst && !flush && (q.size() > 0) && out_ready;
    e = model_enc(opcode, 32'(rd), 32'(rs1), 32'(rs2), 32'(funct3), 32'(funct7), imm);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_acc = 0;
      m_err = 0;
    end else begin
      if (flush) q.delete();
      else if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (m_acc < CNT_MAX) m_acc++;
        if (e.err && m_err < CNT_MAX) m_err++;
      end
    end
    #1;
  endtask

  task automatic req(input logic [6:0] op, input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b, input logic [2:0] f3, input logic [31:0] v);
    in_valid = 1'b1; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = 7'h0; imm = v;
  endtask

  task automatic rand_req();
    int k = int'($urandom_range(0, 9));
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    case (k)
      0: begin opcode = OP_I;     imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
      1: begin opcode = OP_LOAD;  imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
      2: begin opcode = OP_JALR;  imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
      3: begin opcode = OP_S;     imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
      4: begin opcode = OP_B;     imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2); end
      5: begin opcode = OP_LUI;   imm = $urandom & 32'hffff_f000; end
      6: begin opcode = OP_AUIPC; imm = $urandom & 32'hffff_f000; end
      7: begin opcode = OP_JAL;   imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2); end
      8: begin opcode = OP_R;     imm = $urandom; end
      default: begin opcode = 7'($urandom); imm = $urandom; end
    endcase
    if ($urandom_range(0, 7) == 0) imm = $urandom;
  endtask

  typedef struct { logic [6:0] op; logic [31:0] v; } bnd_t;
  bnd_t bnd[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 7'h0; rd = 5'h0; rs1 = 5'h0; rs2 = 5'h0; funct3 = 3'h0; funct7 = 7'h0; imm = 32'h0;
    m_acc = 0; m_err = 0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    out_ready = 1'b1;
    req(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'hffff_ffff); cycle(); in_valid = 1'b0;
    check("addi_word", out_inst, 32'hfff0_0093);
    check("addi_err", out_err, 1'b0);
    cycle();
    req(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8); cycle(); in_valid = 1'b0;
    check("beq_word", out_inst, 32'h0020_8463);
    cycle();
    req(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 32'd7); cycle(); in_valid = 1'b0;
    check("beq_odd_word", out_inst, 32'h0000_0013);
    check("beq_odd_err", out_err, 1'b1);
    cycle();
    req(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048); cycle(); in_valid = 1'b0;
    check("jal_word", out_inst, 32'h0010_00ef);
    cycle();
    req(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000); cycle(); in_valid = 1'b0;
    check("lui_word", out_inst, 32'h1234_52b7);
    cycle();
    req(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001); cycle(); in_valid = 1'b0;
    check("lui_bad_err", out_err, 1'b1);
    cycle();

    bnd = '{'{OP_I, 32'd2047}, '{OP_I, 32'd2048}, '{OP_S, 32'hffff_f800}, '{OP_S, 32'hffff_f7ff},
            '{OP_B, 32'd4094}, '{OP_B, 32'd4096}, '{OP_B, 32'hffff_f000}, '{OP_B, 32'hffff_effe},
            '{OP_JAL, 32'd1048574}, '{OP_JAL, 32'd1048576}, '{OP_JAL, 32'hfff0_0000},
            '{OP_AUIPC, 32'hffff_f000}, '{7'h7f, 32'h0}};
    foreach (bnd[i]) begin
      req(bnd[i].op, 5'(i), 5'(i + 3), 5'(i + 7), 3'(i), bnd[i].v);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();

    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      req(OP_I, 5'(i + 1), 5'd2, 5'd0, 3'd0, 32'(i * 100));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();

    out_ready = 1'b0;
    req(OP_R, 5'd3, 5'd4, 5'd5, 3'd1, 32'h0); cycle();
    req(OP_S, 5'd0, 5'd4, 5'd5, 3'd2, 32'd12); cycle();
    flush = 1'b1; req(OP_I, 5'd9, 5'd9, 5'd0, 3'd0, 32'd1); cycle();
    flush = 1'b0; in_valid = 1'b0; cycle();
    check("flush_empty", out_valid, 1'b0);

    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rand_req();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = (i == 400);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
